seq_1101_tx: RTL
================

SEQ_1101_TX -- requirements
Module: seq_1101_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal 1..16).
REQ-002 Parameter PREAMBLE, default 4'b1101, 4-bit frame preamble, sent MSB first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to send one frame; sampled only when ready=1.
REQ-006 data_in  input  DATA_W  payload; captured on the edge where start is accepted.
REQ-007 ready  output  1  high only in IDLE; start accepted.
REQ-008 seq_out  output  1  registered serial line, one bit per clk.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking the final (STOP) bit of a frame.
REQ-011 crnt_state  output  3  registered FSM state, for debug.
REQ-012 nxt_state  output  3  combinational next state, for debug.

Function
REQ-013 States SHALL be encoded IDLE=000, PRE=001, DATA=010, PAR=011, STOP=100; 101-111 SHALL return to IDLE on the next edge.
REQ-014 IDLE: seq_out=0, ready=1; start=1 -> capture data_in into shift register, clear bit counter, go to PRE.
REQ-015 PRE: seq_out SHALL drive PREAMBLE[3], [2], [1], [0] on 4 consecutive cycles, then go to DATA.
REQ-016 DATA: seq_out SHALL drive the captured payload MSB first, one bit per cycle, for exactly DATA_W cycles.
REQ-017 After the last DATA bit -> PAR when PARITY_EN is defined, else -> STOP.
REQ-018 STOP: seq_out=0 for one cycle, done=1 in that cycle, then IDLE unconditionally.
REQ-019 First preamble bit SHALL appear on seq_out in the cycle after the accepting edge (1-cycle latency).
REQ-020 Frame length SHALL be 4+DATA_W+1 cycles (+1 with PARITY_EN); minimum start-to-start spacing is frame length + 1 IDLE cycle.
REQ-021 start while busy (including STOP) SHALL be ignored and not queued.
REQ-022 Changes on data_in after acceptance SHALL NOT affect the frame in flight.
REQ-023 Bit counter SHALL be ceil(log2(DATA_W+1)) bits, SHALL NOT wrap within a frame, and SHALL be cleared on entry to PRE.

Reset
REQ-024 reset=1 at a rising edge SHALL force crnt_state=IDLE, seq_out=0, done=0, busy=0, ready=1, counter=0, shift register=0.
REQ-025 reset SHALL take priority over start in the same cycle.
REQ-026 reset mid-frame SHALL abort the frame with no done pulse; the next start after reset release SHALL send a complete new frame.

Configuration
REQ-027 Macro PARITY_EN: when defined, PAR state SHALL drive one even-parity bit (XOR of all payload bits) between DATA and STOP.
REQ-028 Without PARITY_EN, no PAR state logic SHALL be built, and the DATA state SHALL go directly to STOP.

Verification
REQ-029 Reset 2 cycles, start=1 with data_in=8'hA5 for 1 cycle -> seq_out = 1,1,0,1, 1,0,1,0,0,1,0,1, 0; done high on cycle 13 only.
REQ-030 Same as REQ-029 with PARITY_EN, data_in=8'h07 -> preamble, 00000111, parity bit 1, stop 0; done on cycle 14.
REQ-031 Hold start=1 continuously with data_in=8'hFF -> frames separated by exactly one IDLE cycle (seq_out=0, ready=1).
REQ-032 Pulse start at the 3rd DATA bit with data_in changed to 8'h00 -> in-flight frame unchanged, no second frame.
REQ-033 Assert reset during the 5th DATA bit -> next edge: crnt_state=000, seq_out=0, done never pulses for that frame.
REQ-034 Throughout all scenarios -> busy == ~ready, and nxt_state equals crnt_state one cycle later.

Source files
------------

// File: rtl/seq_1101_tx.sv
// Serial frame transmitter: 4-bit preamble, DATA_W payload bits MSB first, optional
// even-parity bit (enabled by defining PARITY_EN), then one low STOP bit with a done pulse.
//
//   state | meaning
//   IDLE  | line low, ready for start
//   PRE   | shifting out the 4 preamble bits
//   DATA  | shifting out the captured payload, MSB first
//   PAR   | even parity of the payload (PARITY_EN builds only)
//   STOP  | line low for one cycle, done asserted
module seq_1101_tx #(
    parameter int unsigned DATA_W   = 8,
    parameter logic [3:0]  PREAMBLE = 4'b1101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              seq_out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        crnt_state,
    output logic [2:0]        nxt_state
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_PRE  = 3'b001;
    localparam logic [2:0] S_DATA = 3'b010;
`ifdef PARITY_EN
    localparam logic [2:0] S_PAR  = 3'b011;
`endif
    localparam logic [2:0] S_STOP = 3'b100;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [1:0]        r_pre_cnt;
    logic              r_seq_out;
    logic              r_done;
`ifdef PARITY_EN
    logic              r_parity;
`endif

    logic [2:0]        w_nxt_state;
    logic [DATA_W-1:0] w_nxt_shift;
    logic [1:0]        w_nxt_pre_cnt;
    logic              w_nxt_seq_out;
    logic              w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // Reset folded in so the debug next-state always predicts the following state.
    always_comb begin
        w_nxt_state = S_IDLE;
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_nxt_state = start ? S_PRE : S_IDLE;
                S_PRE:   w_nxt_state = (r_pre_cnt == 2'd3) ? S_DATA : S_PRE;
`ifdef PARITY_EN
                S_DATA:  w_nxt_state = (r_bit_cnt == LAST_BIT) ? S_PAR : S_DATA;
                S_PAR:   w_nxt_state = S_STOP;
`else
                S_DATA:  w_nxt_state = (r_bit_cnt == LAST_BIT) ? S_STOP : S_DATA;
`endif
                S_STOP:  w_nxt_state = S_IDLE;
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_nxt_shift = r_shift;
        if (w_accept) begin
            w_nxt_shift = data_in;
        end else if (r_state == S_DATA) begin
            w_nxt_shift = r_shift << 1;
        end
    end

    assign w_nxt_pre_cnt = (r_state == S_PRE) ? r_pre_cnt + 2'd1 : 2'd0;

    // The line is registered, so it is computed from where the FSM is headed.
    always_comb begin
        w_nxt_seq_out = 1'b0;
        case (w_nxt_state)
            S_PRE:   w_nxt_seq_out = PREAMBLE[2'd3 - w_nxt_pre_cnt];
            S_DATA:  w_nxt_seq_out = w_nxt_shift[DATA_W-1];
`ifdef PARITY_EN
            S_PAR:   w_nxt_seq_out = r_parity;
`endif
            default: w_nxt_seq_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pre_cnt <= 2'd0;
            r_seq_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_shift   <= w_nxt_shift;
            r_pre_cnt <= w_nxt_pre_cnt;
            r_seq_out <= w_nxt_seq_out;
            r_done    <= (w_nxt_state == S_STOP);
            if (w_accept) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end
`endif

    assign ready      = (r_state == S_IDLE);
    assign busy       = ~ready;
    assign seq_out    = r_seq_out;
    assign done       = r_done;
    assign crnt_state = r_state;
    assign nxt_state  = w_nxt_state;

endmodule
